// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with registered reads and a pending scoreboard.
// Define REGFILE_BYPASS_EN for write-through on same-cycle read/write collisions.
module regfile_multiport #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid,
    output logic [NUM_RD_PORTS-1:0]            rd_busy,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               pend_set,
    input  logic [ADDR_WIDTH-1:0]              pend_addr,
    output logic                               any_pending
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;

    logic [ADDR_WIDTH-1:0] rd_idx [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0] rd_val [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] wr_hit;
    logic [NUM_RD_PORTS-1:0] pend_hit;

    logic wr_ok;
    logic pend_ok;

    assign wr_ok   = wr_en && (wr_addr != '0);
    assign pend_ok = pend_set && (pend_addr != '0);

    genvar gp;
    generate
        for (gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rd
            assign rd_idx[gp]   = rd_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_hit[gp]   = wr_en && (wr_addr == rd_idx[gp]);
            assign pend_hit[gp] = pend_set && (pend_addr == rd_idx[gp]);
`ifdef REGFILE_BYPASS_EN
            assign rd_val[gp] = (rd_idx[gp] == '0) ? '0 :
                                wr_hit[gp] ? wr_data : regs[rd_idx[gp]];
            // A completing producer clears the hazard unless a new one re-marks it.
            assign rd_busy[gp] = pending[rd_idx[gp]] &&
                                 !(wr_hit[gp] && !pend_hit[gp]);
`else
            assign rd_val[gp] = (rd_idx[gp] == '0) ? '0 : regs[rd_idx[gp]];
            assign rd_busy[gp] = pending[rd_idx[gp]];
`endif
        end
    endgenerate

    assign any_pending = |pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so a same-address re-mark wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[wr_addr] <= 1'b0;
            end
            if (pend_ok) begin
                pending[pend_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                rd_valid[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_val[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Vector-table bench for regfile_multiport; read results are queued at drive
// time and popped one edge later.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        any_pending;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    regfile_multiport #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_RD_PORTS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_busy(rd_busy),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .pend_set(pend_set),
        .pend_addr(pend_addr),
        .any_pending(any_pending)
    );

    typedef struct {
        bit          rst;
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [4:0]  a1;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ps;
        logic [4:0]  pa;
        logic [1:0]  ev;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        bit          any;
    } vec_t;

    typedef struct {
        logic [1:0]  ev;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          any;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input bit rst, input logic [1:0] en,
        input logic [4:0] a0, input logic [4:0] a1,
        input bit we, input logic [4:0] wa, input logic [31:0] wd,
        input bit ps, input logic [4:0] pa,
        input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] busy, input bit any);
        vec_t v;
        v.rst = rst; v.en = en; v.a0 = a0; v.a1 = a1;
        v.we = we; v.wa = wa; v.wd = wd; v.ps = ps; v.pa = pa;
        v.ev = ev; v.d0 = d0; v.d1 = d1; v.busy = busy; v.any = any;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        exp_t e;
        @(negedge clock);
        reset     = v.rst;
        rd_en     = v.en;
        rd_addr   = {v.a1, v.a0};
        wr_en     = v.we;
        wr_addr   = v.wa;
        wr_data   = v.wd;
        pend_set  = v.ps;
        pend_addr = v.pa;
        #1;
        chk("rd_busy", idx, {30'd0, rd_busy}, {30'd0, v.busy});
        e.ev = v.ev; e.d0 = v.d0; e.d1 = v.d1; e.any = v.any;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            chk("rd_valid", idx, {30'd0, rd_valid}, {30'd0, e.ev});
            chk("rd_data0", idx, rd_data[31:0], e.d0);
            chk("rd_data1", idx, rd_data[63:32], e.d1);
            chk("any_pending", idx, {31'd0, any_pending}, {31'd0, e.any});
        end
    endtask

    initial begin
        reset = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; pend_set = 1'b0; pend_addr = '0;
        repeat (2) @(posedge clock);

        // rst en a0 a1 we wa wd ps pa | ev d0 d1 busy any
        tbl.push_back(mk(1, 2'b11, 0, 7, 0, 0, 0, 0, 0,
                         2'b00, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 0, 7, 0, 0, 0, 0, 0,
                         2'b11, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 3, 3, 1, 3, 32'hDEADBEEF, 0, 0,
                         2'b00, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 3, 3, 0, 0, 0, 0, 0,
                         2'b01, 32'hDEADBEEF, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0,
                         2'b00, 32'hDEADBEEF, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 0, 3, 0, 0, 0, 0, 0,
                         2'b11, 0, 32'hDEADBEEF, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 5, 5, 1, 5, 32'h11, 0, 0,
                         2'b00, 0, 32'hDEADBEEF, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 5, 5, 1, 5, 32'h22, 0, 0,
                         2'b01, BYP ? 32'h22 : 32'h11, 32'hDEADBEEF, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 5, 5, 0, 0, 0, 0, 0,
                         2'b11, 32'h22, 32'h22, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 9, 9, 0, 0, 0, 1, 9,
                         2'b00, 32'h22, 32'h22, 2'b00, 1));
        tbl.push_back(mk(0, 2'b00, 9, 5, 0, 0, 0, 0, 0,
                         2'b00, 32'h22, 32'h22, 2'b01, 1));
        tbl.push_back(mk(0, 2'b00, 9, 9, 1, 9, 32'h99, 1, 9,
                         2'b00, 32'h22, 32'h22, 2'b11, 1));
        tbl.push_back(mk(0, 2'b00, 9, 9, 1, 9, 32'h9A, 0, 0,
                         2'b00, 32'h22, 32'h22, BYP ? 2'b00 : 2'b11, 0));
        tbl.push_back(mk(0, 2'b00, 9, 9, 0, 0, 0, 0, 0,
                         2'b00, 32'h22, 32'h22, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 12, 13, 1, 13, 32'h13, 1, 12,
                         2'b00, 32'h22, 32'h22, 2'b00, 1));
        tbl.push_back(mk(0, 2'b11, 12, 13, 0, 0, 0, 0, 0,
                         2'b11, 0, 32'h13, 2'b01, 1));
        tbl.push_back(mk(0, 2'b00, 12, 13, 1, 12, 32'h0C, 0, 0,
                         2'b00, 0, 32'h13, BYP ? 2'b00 : 2'b01, 0));
        tbl.push_back(mk(0, 2'b11, 12, 12, 0, 0, 0, 0, 0,
                         2'b11, 32'h0C, 32'h0C, 2'b00, 0));

        foreach (tbl[i]) run(tbl[i], i);

        // Load 1..4, mark 2, then reset mid-operation with reads requested.
        run(mk(0, 2'b00, 1, 2, 1, 1, 32'hA1, 0, 0,
               2'b00, 32'h0C, 32'h0C, 2'b00, 0), 100);
        run(mk(0, 2'b00, 1, 2, 1, 2, 32'hA2, 0, 0,
               2'b00, 32'h0C, 32'h0C, 2'b00, 0), 101);
        run(mk(0, 2'b00, 1, 2, 1, 3, 32'hA3, 0, 0,
               2'b00, 32'h0C, 32'h0C, 2'b00, 0), 102);
        run(mk(0, 2'b00, 1, 2, 1, 4, 32'hA4, 1, 2,
               2'b00, 32'h0C, 32'h0C, 2'b00, 1), 103);
        run(mk(0, 2'b11, 1, 2, 0, 0, 0, 0, 0,
               2'b11, 32'hA1, 32'hA2, 2'b10, 1), 104);
        run(mk(1, 2'b11, 3, 4, 1, 6, 32'h66, 1, 7,
               2'b00, 0, 0, 2'b00, 0), 105);
        run(mk(0, 2'b11, 1, 2, 0, 0, 0, 0, 0,
               2'b11, 0, 0, 2'b00, 0), 106);
        run(mk(0, 2'b11, 3, 4, 0, 0, 0, 0, 0,
               2'b11, 0, 0, 2'b00, 0), 107);
        run(mk(0, 2'b11, 6, 7, 0, 0, 0, 0, 0,
               2'b11, 0, 0, 2'b00, 0), 108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
